// File: rtl/decl_stmt_pkg.sv
// Shared constants, FSM state encodings and character classification for the
// declaration-statement checker.
package decl_stmt_pkg;

  localparam logic [7:0] CH_SP    = 8'd32;
  localparam logic [7:0] CH_TAB   = 8'd9;
  localparam logic [7:0] CH_LF    = 8'd10;
  localparam logic [7:0] CH_CR    = 8'd13;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_SEMI  = 8'h3B;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_T     = 8'h74;
  localparam logic [7:0] CH_C     = 8'h63;
  localparam logic [7:0] CH_H     = 8'h68;
  localparam logic [7:0] CH_A     = 8'h61;
  localparam logic [7:0] CH_R     = 8'h72;

  localparam logic [2:0] ST_START = 3'd0;
  localparam logic [2:0] ST_TYPE  = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_IDENT = 3'd3;
  localparam logic [2:0] ST_POST  = 3'd4;
  localparam logic [2:0] ST_SKIP  = 3'd5;

  typedef struct packed {
    logic ws;
    logic id_start;
    logic id_char;
    logic comma;
    logic semi;
  } char_class_t;

  function automatic char_class_t classify(input logic [7:0] c);
    char_class_t r;
    logic alpha;
    logic digit;
    alpha      = (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    digit      = (c >= 8'h30 && c <= 8'h39);
    r.ws       = (c == CH_SP) || (c == CH_TAB) || (c == CH_LF) || (c == CH_CR);
    r.id_start = alpha || (c == 8'h5F);
    r.id_char  = alpha || digit || (c == 8'h5F);
    r.comma    = (c == CH_COMMA);
    r.semi     = (c == CH_SEMI);
    return r;
  endfunction

  // Keyword letter at position idx; sel=0 spells "int", sel=1 spells "char".
  function automatic logic [7:0] kw_char(input logic sel, input logic [2:0] idx);
    logic [7:0] r;
    case ({sel, idx})
      4'b0_000: r = CH_I;
      4'b0_001: r = CH_N;
      4'b0_010: r = CH_T;
      4'b1_000: r = CH_C;
      4'b1_001: r = CH_H;
      4'b1_010: r = CH_A;
      4'b1_011: r = CH_R;
      default:  r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decl_char_class.sv
// Combinational character classifier feeding the statement FSM.
module decl_char_class
  import decl_stmt_pkg::*;
(
  input  logic [7:0]  ch_i,
  output char_class_t cls_c
);

  assign cls_c = classify(ch_i);

endmodule

// File: rtl/decl_stmt_checker.sv
// Streaming checker for "TYPE id (, id)* ;" declarations, one character per beat.
// Reports ok/err per ';' and holds type and identifier count of the last good statement.
module decl_stmt_checker
  import decl_stmt_pkg::*;
#(
  parameter int unsigned ENABLE_CHAR = 1,
  parameter int unsigned MAX_ID_LEN  = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic             ok,
  output logic             err,
  output logic             decl_type,
  output logic [CNT_W-1:0] id_count
);

  localparam int unsigned    LEN_W   = $clog2(MAX_ID_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic           CHAR_ON = (ENABLE_CHAR != 0);

  char_class_t cls;

  logic [2:0]       state_q,     state_d;
  logic             type_sel_q,  type_sel_d;
  logic [2:0]       type_idx_q,  type_idx_d;
  logic [LEN_W-1:0] id_len_q,    id_len_d;
  logic [CNT_W-1:0] id_cnt_q,    id_cnt_d;
  logic             m_int_q,     m_int_d;
  logic             m_char_q,    m_char_d;
  logic             ok_q,        ok_d;
  logic             err_q,       err_d;
  logic             decl_type_q, decl_type_d;
  logic [CNT_W-1:0] id_count_q,  id_count_d;

  logic type_done;
  logic commit_bad;
  logic kw_pos_ok;

  decl_char_class u_class (
    .ch_i  (in),
    .cls_c (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_START;
      type_sel_q  <= 1'b0;
      type_idx_q  <= 3'd0;
      id_len_q    <= '0;
      id_cnt_q    <= '0;
      m_int_q     <= 1'b0;
      m_char_q    <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      decl_type_q <= 1'b0;
      id_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      type_sel_q  <= type_sel_d;
      type_idx_q  <= type_idx_d;
      id_len_q    <= id_len_d;
      id_cnt_q    <= id_cnt_d;
      m_int_q     <= m_int_d;
      m_char_q    <= m_char_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      decl_type_q <= decl_type_d;
      id_count_q  <= id_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    type_sel_d  = type_sel_q;
    type_idx_d  = type_idx_q;
    id_len_d    = id_len_q;
    id_cnt_d    = id_cnt_q;
    m_int_d     = m_int_q;
    m_char_d    = m_char_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    decl_type_d = decl_type_q;
    id_count_d  = id_count_q;

    type_done  = (type_idx_q == (type_sel_q ? 3'd4 : 3'd3));
    // An identifier is rejected at commit if it spells a keyword or the count is full.
    commit_bad = (m_int_q && id_len_q == LEN_W'(3)) ||
                 (m_char_q && id_len_q == LEN_W'(4)) ||
                 (id_cnt_q == CNT_MAX);
    kw_pos_ok  = (id_len_q < LEN_W'(4));

    if (in_valid) begin
      case (state_q)
        ST_START: begin
          if (cls.ws) begin
            state_d = ST_START;
          end else if (in == CH_I) begin
            state_d    = ST_TYPE;
            type_sel_d = 1'b0;
            type_idx_d = 3'd1;
          end else if (CHAR_ON && in == CH_C) begin
            state_d    = ST_TYPE;
            type_sel_d = 1'b1;
            type_idx_d = 3'd1;
          end else if (cls.semi) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_TYPE: begin
          if (cls.semi) begin
            err_d   = 1'b1;
            state_d = ST_START;
          end else if (type_done) begin
            state_d = cls.ws ? ST_GAP : ST_SKIP;
          end else if (in == kw_char(type_sel_q, type_idx_q)) begin
            type_idx_d = type_idx_q + 3'd1;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_GAP: begin
          if (cls.ws) begin
            state_d = ST_GAP;
          end else if (cls.id_start) begin
            state_d  = ST_IDENT;
            id_len_d = LEN_W'(1);
            m_int_d  = (in == CH_I);
            m_char_d = CHAR_ON && (in == CH_C);
          end else if (cls.semi) begin
            err_d   = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_IDENT: begin
          if (cls.id_char) begin
            if (id_len_q == LEN_W'(MAX_ID_LEN)) begin
              state_d = ST_SKIP;
            end else begin
              id_len_d = id_len_q + LEN_W'(1);
              m_int_d  = m_int_q && kw_pos_ok && (in == kw_char(1'b0, 3'(id_len_q)));
              m_char_d = m_char_q && kw_pos_ok && (in == kw_char(1'b1, 3'(id_len_q)));
            end
          end else if (cls.ws || cls.comma || cls.semi) begin
            if (commit_bad) begin
              if (cls.semi) begin
                err_d   = 1'b1;
                state_d = ST_START;
              end else begin
                state_d = ST_SKIP;
              end
            end else begin
              id_cnt_d = id_cnt_q + CNT_W'(1);
              if (cls.ws) begin
                state_d = ST_POST;
              end else if (cls.comma) begin
                state_d = ST_GAP;
              end else begin
                ok_d        = 1'b1;
                id_count_d  = id_cnt_q + CNT_W'(1);
                decl_type_d = type_sel_q;
                state_d     = ST_START;
              end
            end
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_POST: begin
          if (cls.ws) begin
            state_d = ST_POST;
          end else if (cls.comma) begin
            state_d = ST_GAP;
          end else if (cls.semi) begin
            ok_d        = 1'b1;
            id_count_d  = id_cnt_q;
            decl_type_d = type_sel_q;
            state_d     = ST_START;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (cls.semi) begin
            err_d   = 1'b1;
            state_d = ST_START;
          end
        end
        default: state_d = ST_START;
      endcase
    end

    // Every terminated statement starts the next one with an empty id count.
    if (ok_d || err_d) begin
      id_cnt_d = '0;
    end
  end

  assign ok        = ok_q;
  assign err       = err_q;
  assign decl_type = decl_type_q;
  assign id_count  = id_count_q;

endmodule

// File: tb/tb_decl_stmt_checker.sv
// Scoreboard bench: two checkers (char enabled / disabled) fed the same character stream.
module tb_decl_stmt_checker;

  typedef struct {
    logic       ok;
    logic       ty;
    logic [3:0] cnt;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_ch = 8'h00;

  logic       ok1, err1, ty1;
  logic [3:0] cnt1;
  logic       ok0, err0, ty0;
  logic [3:0] cnt0;

  exp_t q1[$];
  exp_t q0[$];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic       h1_ty = 1'b0, h0_ty = 1'b0;
  logic [3:0] h1_cnt = 4'd0, h0_cnt = 4'd0;

  decl_stmt_checker #(.ENABLE_CHAR(1), .MAX_ID_LEN(8), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .ok(ok1), .err(err1), .decl_type(ty1), .id_count(cnt1)
  );

  decl_stmt_checker #(.ENABLE_CHAR(0), .MAX_ID_LEN(8), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in_ch),
    .ok(ok0), .err(err0), .decl_type(ty0), .id_count(cnt0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_evt(input string name, input bit have, input exp_t e,
                         input logic ok, input logic err, input logic ty, input logic [3:0] cnt);
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s unexpected pulse: ok=%0b err=%0b cyc=%0d", name, ok, err, cyc);
    end else if (ok !== e.ok || err !== !e.ok || ty !== e.ty || cnt !== e.cnt || cyc != e.cyc) begin
      failures++;
      $display("FAIL %s: got ok=%0b err=%0b type=%0b cnt=%0d cyc=%0d, want ok=%0b err=%0b type=%0b cnt=%0d cyc=%0d",
               name, ok, err, ty, cnt, cyc, e.ok, !e.ok, e.ty, e.cnt, e.cyc);
    end
  endtask

  // Monitor: pops one expectation per ok/err pulse seen on each DUT.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!reset) begin
      if (ok1 || err1) begin
        have = (q1.size() != 0);
        if (have) e = q1.pop_front();
        chk_evt("dut_char_on", have, e, ok1, err1, ty1, cnt1);
      end
      if (ok0 || err0) begin
        have = (q0.size() != 0);
        if (have) e = q0.pop_front();
        chk_evt("dut_char_off", have, e, ok0, err0, ty0, cnt0);
      end
    end
  end

  task automatic beat(input logic [7:0] c, input bit v);
    in_ch    = c;
    in_valid = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends s (ending in ';'); gap inserts an idle beat carrying ';' with in_valid=0.
  task automatic stmt(input string s, input bit gap,
                      input bit ok1e, input bit t1, input int n1,
                      input bit ok0e, input bit t0, input int n0);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      beat(s[i], 1'b1);
      if (gap && i != s.len() - 1) begin
        beat(8'h3B, 1'b0);
        beat(8'h20, 1'b0);
      end
    end
    if (ok1e) begin h1_ty = t1; h1_cnt = 4'(n1); end
    if (ok0e) begin h0_ty = t0; h0_cnt = 4'(n0); end
    e.cyc = cyc;
    e.ok = ok1e; e.ty = h1_ty; e.cnt = h1_cnt; q1.push_back(e);
    e.ok = ok0e; e.ty = h0_ty; e.cnt = h0_cnt; q0.push_back(e);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (ok1 !== 1'b0 || err1 !== 1'b0 || ty1 !== 1'b0 || cnt1 !== 4'd0 ||
        ok0 !== 1'b0 || err0 !== 1'b0 || ty0 !== 1'b0 || cnt0 !== 4'd0) begin
      failures++;
      $display("FAIL %s: got on:%0b%0b%0b/%0d off:%0b%0b%0b/%0d, want all zero",
               name, ok1, err1, ty1, cnt1, ok0, err0, ty0, cnt0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_zero("reset_state");

    stmt("int a,b;", 0, 1, 0, 2, 1, 0, 2);
    stmt("  char\tx_1 , _y ;", 0, 1, 1, 2, 0, 0, 0);
    stmt("int int;", 0, 0, 0, 0, 0, 0, 0);
    stmt("int intx;", 0, 1, 0, 1, 1, 0, 1);
    stmt("int abcdefghi;", 0, 0, 0, 0, 0, 0, 0);
    stmt("int abcdefgh;", 0, 1, 0, 1, 1, 0, 1);
    stmt("int a,,b;", 0, 0, 0, 0, 0, 0, 0);
    stmt("int 1a;", 0, 0, 0, 0, 0, 0, 0);
    stmt(";", 0, 0, 0, 0, 0, 0, 0);
    stmt("x;", 0, 0, 0, 0, 0, 0, 0);
    stmt("int q;", 0, 1, 0, 1, 1, 0, 1);
    stmt("char cha;", 0, 1, 1, 1, 0, 0, 0);
    stmt("int char;", 0, 0, 0, 0, 1, 0, 1);
    stmt("int in,i ;", 0, 1, 0, 2, 1, 0, 2);
    stmt("int a,b,c,d,e,f,g,h,i,j,k,l,m,n,o;", 0, 1, 0, 15, 1, 0, 15);
    stmt("int a,b,c,d,e,f,g,h,i,j,k,l,m,n,o,p;", 0, 0, 0, 0, 0, 0, 0);
    stmt("intx a;", 0, 0, 0, 0, 0, 0, 0);
    stmt("in a;", 0, 0, 0, 0, 0, 0, 0);
    stmt("int\na\r;", 0, 1, 0, 1, 1, 0, 1);
    stmt("char z;", 0, 1, 1, 1, 0, 0, 0);
    stmt("int a;", 1, 1, 0, 1, 1, 0, 1);

    // Reset mid-statement, with a ';' presented during reset.
    beat("i", 1); beat("n", 1); beat("t", 1); beat(" ", 1); beat("a", 1);
    reset    = 1'b1;
    in_ch    = 8'h3B;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    h1_ty = 1'b0; h1_cnt = 4'd0; h0_ty = 1'b0; h0_cnt = 4'd0;
    chk_zero("mid_reset_state");
    stmt("int b;", 0, 1, 0, 1, 1, 0, 1);

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q1.size() != 0) begin
      failures++;
      $display("FAIL drain_char_on: got %0d pending, want 0", q1.size());
    end
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL drain_char_off: got %0d pending, want 0", q0.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
